kronos_wb: RTL and testbench

KRONOS_WB -- requirements
Module: kronos_wb

---
 rtl/kronos_types.sv | 51 +++++
 rtl/kronos_lsu_align.sv | 41 ++++
 rtl/kronos_wb.sv | 191 +++++++++++++++++++
 tb/tb_kronos_wb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// Shared types and constants for the Kronos writeback stage.
package kronos_types;

  // Memory access width carried in the data_size field of the EX result.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } data_size_e;

  // Trap causes raised by the writeback stage itself.
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  // EX -> WB pipeline payload.
  typedef struct packed {
    logic [31:0] result1;      // ALU value, link value or store data
    logic [31:0] result2;      // effective address or branch target
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic        ld;
    logic        st;
    logic [1:0]  data_size;
    logic        data_uns;
    logic        except;
    logic [3:0]  excause;
  } pipeEXWB_t;

  // Writeback sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } wb_state_e;

  // Halves need an even address, words (and the unused size code) need a
  // 4-byte aligned address; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == HALF) begin
      mis = addr_lo[0];
    end else if (size != BYTE) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/kronos_lsu_align.sv
// Byte-lane steering for the data bus: store data/mask placement and
// load data extraction with sign or zero extension.
module kronos_lsu_align
  import kronos_types::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic [31:0] wr_data,
  output logic [3:0]  mask,
  output logic [31:0] ld_data
);

  logic [4:0]  shamt;
  logic [31:0] rd_shifted;

  assign shamt = {addr_lo, 3'b000};

  // Place store data in its lanes and pick out the addressed load lanes.
  always_comb begin
    wr_data    = st_data << shamt;
    rd_shifted = rd_data >> shamt;
    case (size)
      BYTE: begin
        mask    = 4'b0001 << addr_lo;
        ld_data = uns ? {24'h0, rd_shifted[7:0]} : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      end
      HALF: begin
        mask    = 4'b0011 << addr_lo;
        ld_data = uns ? {16'h0, rd_shifted[15:0]} : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      end
      default: begin
        mask    = 4'b1111;
        ld_data = rd_shifted;
      end
    endcase
  end

endmodule

// File: rtl/kronos_wb.sv
// Kronos writeback stage: register writeback, branch redirect, trap report
// and a single outstanding load/store on the data bus.
module kronos_wb
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pipeEXWB_t   execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic        regwr_en,
  output logic [4:0]  regwr_sel,
  output logic [31:0] regwr_data,
  output logic        branch_vld,
  output logic [31:0] branch_target,
  output logic        data_req,
  output logic        data_wr_en,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  input  logic        data_ack,
  input  logic [31:0] data_rd_data,
  output logic        trap_vld,
  output logic [3:0]  trap_cause
);

  wb_state_e   state, state_nxt;
  logic        accept;
  logic        misaligned;

  logic        regwr_en_nxt, branch_vld_nxt, trap_vld_nxt;
  logic [4:0]  regwr_sel_nxt;
  logic [31:0] regwr_data_nxt, branch_target_nxt;
  logic        data_req_nxt, data_wr_en_nxt;
  logic [31:0] data_addr_nxt, data_wr_data_nxt;
  logic [3:0]  data_mask_nxt, trap_cause_nxt;

  // Destination of the outstanding load, captured at accept.
  logic [4:0]  ld_rd, ld_rd_nxt;
  logic        ld_rd_write, ld_rd_write_nxt;
  logic [1:0]  ld_size, ld_size_nxt;
  logic        ld_uns, ld_uns_nxt;

  logic [1:0]  align_addr, align_size;
  logic        align_uns;
  logic [31:0] align_wr_data, align_ld_data;
  logic [3:0]  align_mask;

  assign pipe_in_rdy = (state == IDLE) && !rst;
  assign accept      = pipe_in_vld && pipe_in_rdy;
  assign misaligned  = is_misaligned(execute.data_size, execute.result2[1:0]);

  // In IDLE the aligner sees the incoming op; while a load is pending it
  // sees the captured load context so the returned data is extracted.
  assign align_addr = (state == IDLE) ? execute.result2[1:0] : data_addr[1:0];
  assign align_size = (state == IDLE) ? execute.data_size    : ld_size;
  assign align_uns  = (state == IDLE) ? execute.data_uns     : ld_uns;

  kronos_lsu_align u_align (
    .addr_lo (align_addr),
    .size    (align_size),
    .uns     (align_uns),
    .st_data (execute.result1),
    .rd_data (data_rd_data),
    .wr_data (align_wr_data),
    .mask    (align_mask),
    .ld_data (align_ld_data)
  );

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch;
    // pulses default low, everything else holds its registered value.
    state_nxt         = state;
    regwr_en_nxt      = 1'b0;
    regwr_sel_nxt     = regwr_sel;
    regwr_data_nxt    = regwr_data;
    branch_vld_nxt    = 1'b0;
    branch_target_nxt = branch_target;
    data_req_nxt      = data_req;
    data_wr_en_nxt    = data_wr_en;
    data_addr_nxt     = data_addr;
    data_wr_data_nxt  = data_wr_data;
    data_mask_nxt     = data_mask;
    trap_vld_nxt      = 1'b0;
    trap_cause_nxt    = trap_cause;
    ld_rd_nxt         = ld_rd;
    ld_rd_write_nxt   = ld_rd_write;
    ld_size_nxt       = ld_size;
    ld_uns_nxt        = ld_uns;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (execute.except) begin
            trap_vld_nxt   = 1'b1;
            trap_cause_nxt = execute.excause;
          end else if ((execute.ld || execute.st) && misaligned) begin
            trap_vld_nxt   = 1'b1;
            trap_cause_nxt = execute.ld ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
          end else if (execute.ld) begin
            state_nxt       = LOAD;
            data_req_nxt    = 1'b1;
            data_wr_en_nxt  = 1'b0;
            data_addr_nxt   = execute.result2;
            data_mask_nxt   = align_mask;
            ld_rd_nxt       = execute.rd;
            ld_rd_write_nxt = execute.rd_write;
            ld_size_nxt     = execute.data_size;
            ld_uns_nxt      = execute.data_uns;
          end else if (execute.st) begin
            state_nxt        = STORE;
            data_req_nxt     = 1'b1;
            data_wr_en_nxt   = 1'b1;
            data_addr_nxt    = execute.result2;
            data_wr_data_nxt = align_wr_data;
            data_mask_nxt    = align_mask;
          end else begin
            // Plain ALU / jump: link write and redirect may coincide.
            regwr_en_nxt      = execute.rd_write && (execute.rd != 5'd0);
            regwr_sel_nxt     = execute.rd;
            regwr_data_nxt    = execute.result1;
            branch_vld_nxt    = execute.branch && (!execute.branch_cond || execute.result1[0]);
            branch_target_nxt = execute.result2;
          end
        end
      end
      LOAD: begin
        if (data_ack) begin
          state_nxt      = IDLE;
          data_req_nxt   = 1'b0;
          regwr_en_nxt   = ld_rd_write && (ld_rd != 5'd0);
          regwr_sel_nxt  = ld_rd;
          regwr_data_nxt = align_ld_data;
        end
      end
      STORE: begin
        if (data_ack) begin
          state_nxt      = IDLE;
          data_req_nxt   = 1'b0;
          data_wr_en_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any bus transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state         <= IDLE;
      regwr_en      <= 1'b0;
      regwr_sel     <= 5'd0;
      regwr_data    <= 32'h0;
      branch_vld    <= 1'b0;
      branch_target <= 32'h0;
      data_req      <= 1'b0;
      data_wr_en    <= 1'b0;
      data_addr     <= 32'h0;
      data_wr_data  <= 32'h0;
      data_mask     <= 4'h0;
      trap_vld      <= 1'b0;
      trap_cause    <= 4'h0;
      ld_rd         <= 5'd0;
      ld_rd_write   <= 1'b0;
      ld_size       <= 2'd0;
      ld_uns        <= 1'b0;
    end else begin
      state         <= state_nxt;
      regwr_en      <= regwr_en_nxt;
      regwr_sel     <= regwr_sel_nxt;
      regwr_data    <= regwr_data_nxt;
      branch_vld    <= branch_vld_nxt;
      branch_target <= branch_target_nxt;
      data_req      <= data_req_nxt;
      data_wr_en    <= data_wr_en_nxt;
      data_addr     <= data_addr_nxt;
      data_wr_data  <= data_wr_data_nxt;
      data_mask     <= data_mask_nxt;
      trap_vld      <= trap_vld_nxt;
      trap_cause    <= trap_cause_nxt;
      ld_rd         <= ld_rd_nxt;
      ld_rd_write   <= ld_rd_write_nxt;
      ld_size       <= ld_size_nxt;
      ld_uns        <= ld_uns_nxt;
    end
  end

endmodule

// File: tb/tb_kronos_wb.sv
// Self-checking bench for kronos_wb: pulse outputs are checked against a
// scoreboard of expected events, bus signals are checked directly.
module tb_kronos_wb;
  import kronos_types::*;

  logic        clk = 1'b0;
  logic        rst;
  pipeEXWB_t   execute;
  logic        pipe_in_vld;
  logic        pipe_in_rdy;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
  logic        branch_vld;
  logic [31:0] branch_target;
  logic        data_req;
  logic        data_wr_en;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_ack;
  logic [31:0] data_rd_data;
  logic        trap_vld;
  logic [3:0]  trap_cause;

  kronos_wb dut (
    .clk           (clk),
    .rst           (rst),
    .execute       (execute),
    .pipe_in_vld   (pipe_in_vld),
    .pipe_in_rdy   (pipe_in_rdy),
    .regwr_en      (regwr_en),
    .regwr_sel     (regwr_sel),
    .regwr_data    (regwr_data),
    .branch_vld    (branch_vld),
    .branch_target (branch_target),
    .data_req      (data_req),
    .data_wr_en    (data_wr_en),
    .data_addr     (data_addr),
    .data_wr_data  (data_wr_data),
    .data_mask     (data_mask),
    .data_ack      (data_ack),
    .data_rd_data  (data_rd_data),
    .trap_vld      (trap_vld),
    .trap_cause    (trap_cause)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_REG = 0, EV_BR = 1, EV_TRAP = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] a;   // regwr_sel / branch_target / trap_cause
    logic [31:0] b;   // regwr_data
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input ev_kind_e kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    if (sb.size() == 0) begin
      check($sformatf("sb_unexpected_kind%0d", int'(kind)), sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check("sb_kind", int'(kind), int'(e.kind));
      check("sb_a", a, e.a);
      if (kind == EV_REG) check("sb_regwr_data", b, e.b);
    end
  endtask

  // Monitor: every pulse observed must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (regwr_en)   pop_cmp(EV_REG,  {27'h0, regwr_sel}, regwr_data);
      if (branch_vld) pop_cmp(EV_BR,   branch_target, 32'h0);
      if (trap_vld)   pop_cmp(EV_TRAP, {28'h0, trap_cause}, 32'h0);
    end
  end

  task automatic issue(input pipeEXWB_t e);
    int n;
    n = 0;
    while (!pipe_in_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pipe_in_rdy) check("rdy_timeout", pipe_in_rdy, 1);
    execute     = e;
    pipe_in_vld = 1'b1;
    @(posedge clk); #1;
    pipe_in_vld = 1'b0;
    execute     = '0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic wr, input logic [31:0] r1);
    pipeEXWB_t e;
    e = '0;
    e.rd = rd; e.rd_write = wr; e.result1 = r1;
    if (wr && rd != 5'd0) expect_ev(EV_REG, {27'h0, rd}, r1);
    issue(e);
  endtask

  task automatic do_branch(input logic cond, input logic [31:0] r1, input logic [31:0] tgt,
                           input logic [4:0] rd, input logic taken);
    pipeEXWB_t e;
    e = '0;
    e.branch = 1'b1; e.branch_cond = cond; e.result1 = r1; e.result2 = tgt;
    e.rd = rd; e.rd_write = (rd != 5'd0);
    if (rd != 5'd0) expect_ev(EV_REG, {27'h0, rd}, r1);
    if (taken) expect_ev(EV_BR, tgt, 32'h0);
    issue(e);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                         input logic [31:0] exp);
    pipeEXWB_t e;
    e = '0;
    e.ld = 1'b1; e.result2 = addr; e.data_size = size; e.data_uns = uns;
    e.rd = rd; e.rd_write = 1'b1;
    issue(e);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("ld_req", data_req, 1);
      check("ld_addr", data_addr, addr);
      check("ld_wr_en", data_wr_en, 0);
      check("ld_rdy_low", pipe_in_rdy, 0);
      @(posedge clk); #1;
    end
    expect_ev(EV_REG, {27'h0, rd}, exp);
    data_ack = 1'b1; data_rd_data = rdata;
    @(posedge clk); #1;
    data_ack = 1'b0; data_rd_data = 32'h0;
    @(negedge clk);
    check("ld_done_req", data_req, 0);
    check("ld_done_rdy", pipe_in_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] r1,
                          input int delay, input logic [31:0] exp_data, input logic [3:0] exp_mask);
    pipeEXWB_t e;
    e = '0;
    e.st = 1'b1; e.result2 = addr; e.result1 = r1; e.data_size = size; e.rd = 5'd9;
    issue(e);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      check("st_req", data_req, 1);
      check("st_wr_en", data_wr_en, 1);
      check("st_addr", data_addr, addr);
      check("st_data", data_wr_data, exp_data);
      check("st_mask", {28'h0, data_mask}, {28'h0, exp_mask});
      if (i == delay) data_ack = 1'b1;
      @(posedge clk); #1;
    end
    data_ack = 1'b0;
    @(negedge clk);
    check("st_done_req", data_req, 0);
    check("st_done_rdy", pipe_in_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_trap(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                         input logic exc, input logic [3:0] excause, input logic [3:0] exp_cause);
    pipeEXWB_t e;
    e = '0;
    e.ld = ld; e.st = !ld; e.result2 = addr; e.data_size = size;
    e.except = exc; e.excause = excause; e.rd = 5'd4; e.rd_write = 1'b1;
    expect_ev(EV_TRAP, {28'h0, exp_cause}, 32'h0);
    issue(e);
    @(negedge clk);
    check("trap_no_req", data_req, 0);
    check("trap_rdy", pipe_in_rdy, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; execute = '0; pipe_in_vld = 1'b0; data_ack = 1'b0; data_rd_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", pipe_in_rdy, 0);
    check("rst_req", data_req, 0);
    check("rst_regwr", regwr_en, 0);
    check("rst_branch", branch_vld, 0);
    check("rst_trap", trap_vld, 0);
    check("rst_addr", data_addr, 0);
    check("rst_regwr_data", regwr_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU writeback and the rd=0 / rd_write=0 suppressions.
    do_alu(5'd5, 1'b1, 32'h1234_5678);
    do_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
    do_alu(5'd7, 1'b0, 32'hCAFE_0001);
    do_alu(5'd31, 1'b1, 32'hA5A5_5A5A);

    // Loads: lane extraction and extension.
    do_load(32'h103, BYTE, 1'b0, 5'd6, 32'h80AA_BBCC, 3, 32'hFFFF_FF80);
    do_load(32'h103, BYTE, 1'b1, 5'd6, 32'h80AA_BBCC, 3, 32'h0000_0080);
    do_load(32'h102, HALF, 1'b0, 5'd8, 32'h80AA_BBCC, 1, 32'hFFFF_80AA);
    do_load(32'h101, BYTE, 1'b0, 5'd2, 32'h80AA_BBCC, 0, 32'hFFFF_FFBB);
    do_load(32'h100, WORD, 1'b0, 5'd3, 32'h80AA_BBCC, 0, 32'h80AA_BBCC);

    // Stores: lane placement and masks, held until ack.
    do_store(32'h202, HALF, 32'h0000_BEEF, 2, 32'hBEEF_0000, 4'b1100);
    do_store(32'h301, BYTE, 32'h0000_0012, 1, 32'h0000_1200, 4'b0010);
    do_store(32'h400, WORD, 32'h1122_3344, 0, 32'h1122_3344, 4'b1111);

    // Traps: misalignment and forwarded exceptions.
    do_trap(1'b1, 32'h101, WORD, 1'b0, 4'd0, EXC_LD_MISALIGN);
    do_trap(1'b0, 32'h203, HALF, 1'b0, 4'd0, EXC_ST_MISALIGN);
    do_trap(1'b1, 32'h101, WORD, 1'b1, 4'd2, 4'd2);

    // Branches: conditional not-taken/taken, unconditional, link-and-jump.
    do_branch(1'b1, 32'h0, 32'h400, 5'd0, 1'b0);
    do_branch(1'b1, 32'h1, 32'h400, 5'd0, 1'b1);
    do_branch(1'b0, 32'h0, 32'h800, 5'd0, 1'b1);
    do_branch(1'b0, 32'h104, 32'h900, 5'd1, 1'b1);

    // Stray ack in IDLE must be ignored.
    data_ack = 1'b1; data_rd_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    data_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_req", data_req, 0);
    check("idle_ack_rdy", pipe_in_rdy, 1);
    @(posedge clk); #1;

    // Reset in the middle of an unacked load aborts it.
    begin
      pipeEXWB_t e;
      e = '0;
      e.ld = 1'b1; e.result2 = 32'h100; e.data_size = WORD; e.rd = 5'd3; e.rd_write = 1'b1;
      issue(e);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_rdy", pipe_in_rdy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_req", data_req, 0);
      check("midrst_idle", pipe_in_rdy, 1);
      data_ack = 1'b1; data_rd_data = 32'h5555_5555;
      @(posedge clk); #1;
      data_ack = 1'b0;
      @(negedge clk);
      check("midrst_no_wb", regwr_en, 0);
      repeat (2) @(posedge clk);
      #1;
    end

    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
